// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle for apb_regfile_slave: master drives the request, slave returns data and response.
interface apb_regfile_slave_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB configuration register file with wait states, byte strobes, read-only status slots,
// error responses and a sticky protocol-violation flag.
module apb_regfile_slave #(
  parameter int                          ADDR_W      = 16,
  parameter int                          DATA_W      = 16,
  parameter int                          NUM_REGS    = 8,
  parameter int                          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]         RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         preset,
  apb_regfile_slave_if.slave           apb,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_q,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic                         prot_err
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IW    = ADDR_W - LSB;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                latch, complete, commit, prot_set;

  logic [ADDR_W-1:0]   addr_p0;
  logic                write_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [NB-1:0]       strb_p0;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [IW-1:0]       idx_full;
  logic [IDX_W-1:0]    sel;
  logic                unaligned, out_of_range, ro_hit, acc_err;
  logic [DATA_W-1:0]   rdata_c;
  logic [NUM_REGS-1:0] pulse_nxt;

  // Address decode runs on the latched setup-phase values so the response is registered-only.
  assign idx_full     = addr_p0[ADDR_W-1:LSB];
  assign sel          = idx_full[IDX_W-1:0];
  assign out_of_range = 32'(idx_full) >= 32'(NUM_REGS);
  assign ro_hit       = RO_MASK[sel];
  assign acc_err      = unaligned || out_of_range || (write_p0 && ro_hit);

  generate
    if (LSB > 0) begin : g_align
      assign unaligned = |addr_p0[LSB-1:0];
    end else begin : g_noalign
      assign unaligned = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    complete  = 1'b0;
    prot_set  = 1'b0;
    case (state)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          latch     = 1'b1;
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = ACCESS;
        end else if (apb.psel && apb.penable) begin
          prot_set = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb.psel || !apb.penable) begin
          prot_set  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
        // The master must hold the request stable; the latched copy is what completes.
        if ((apb.paddr != addr_p0) || (apb.pwrite != write_p0) || (apb.pwdata != wdata_p0))
          prot_set = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign commit = complete && write_p0 && !acc_err;

  always_comb begin
    pulse_nxt = '0;
    if (commit && (|strb_p0))
      pulse_nxt[sel] = 1'b1;
  end

  always_comb begin
    rdata_c = '0;
    if (ro_hit)
      rdata_c = hw_status[sel*DATA_W +: DATA_W];
    else
      rdata_c = regs[sel];
  end

  // Setup stage: capture the request once; no reset needed since ACCESS is only entered through here.
  always_ff @(posedge pclk) begin
    if (latch) begin
      addr_p0  <= apb.paddr;
      write_p0 <= apb.pwrite;
      wdata_p0 <= apb.pwdata;
      strb_p0  <= apb.pstrb;
    end
  end

  // Completion stage: FSM, sticky flag, write pulses and register storage.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      prot_err <= 1'b0;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wr_pulse <= pulse_nxt;
      if (prot_set)
        prot_err <= 1'b1;
      if (commit) begin
        for (int b = 0; b < NB; b++)
          if (strb_p0[b])
            regs[sel][b*8 +: 8] <= wdata_p0[b*8 +: 8];
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
      assign cfg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs[i];
    end
  endgenerate

  assign apb.pready  = (state == ACCESS) && (cnt == 4'd0);
  assign apb.pslverr = apb.pready && acc_err;
  assign apb.prdata  = (apb.pready && !write_p0 && !acc_err) ? rdata_c : '0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: 16-bit data, 8 registers, 2 wait states, register 7 read-only.
module tb_apb_regfile_slave;

  localparam logic [127:0] RV = 128'h0000_0000_0000_0000_0000_00A5_0000_0000;

  logic         pclk;
  logic         preset;
  logic [127:0] hw_status;
  logic [127:0] cfg_q;
  logic [7:0]   wr_pulse;
  logic         prot_err;
  int           checks;
  int           errors;

  apb_regfile_slave_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  apb_regfile_slave #(
    .ADDR_W(16), .DATA_W(16), .NUM_REGS(8), .WAIT_STATES(2),
    .RO_MASK(8'h80), .RESET_VAL(RV)
  ) dut (
    .pclk(pclk), .preset(preset), .apb(bus),
    .hw_status(hw_status), .cfg_q(cfg_q), .wr_pulse(wr_pulse), .prot_err(prot_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Full transfer: setup, access with bounded wait, completion; returns wait count and response.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                      input logic [1:0] strb, output logic [15:0] rd, output logic sl,
                      output int waits, output logic [15:0] rd_wait);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    bus.pstrb   = strb;
    tick();
    bus.penable = 1'b1;
    rd_wait = bus.prdata;
    waits = 0;
    while (!bus.pready && waits < 16) begin
      tick();
      waits++;
    end
    rd = bus.prdata;
    sl = bus.pslverr;
    tick();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  initial begin
    logic [15:0] rd, rdw;
    logic        sl;
    int          w;

    checks = 0;
    errors = 0;
    hw_status   = {16'h0000, {7{16'hDEAD}}};
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
    preset      = 1'b1;
    tick();
    tick();
    check("rst_pready",   bus.pready,  0);
    check("rst_pslverr",  bus.pslverr, 0);
    check("rst_prdata",   bus.prdata,  0);
    check("rst_wr_pulse", wr_pulse,    0);
    check("rst_prot_err", prot_err,    0);
    check("rst_cfg_q",    cfg_q,       RV);
    preset = 1'b0;
    tick();

    // Read of the register with a non-zero reset value
    xfer(1'b0, 16'h0004, 16'h0000, 2'b00, rd, sl, w, rdw);
    check("t1_waits",   w,   2);
    check("t1_wait_rd", rdw, 0);
    check("t1_prdata",  rd,  16'h00A5);
    check("t1_pslverr", sl,  0);

    // Byte-lane write into register 5
    xfer(1'b1, 16'h000A, 16'h1234, 2'b11, rd, sl, w, rdw);
    check("t2_init_err", sl, 0);
    xfer(1'b1, 16'h000A, 16'hBEEF, 2'b01, rd, sl, w, rdw);
    check("t2_pslverr",  sl,               0);
    check("t2_pulse",    wr_pulse,         8'h20);
    check("t2_cfg5",     cfg_q[95:80],     16'h12EF);
    tick();
    check("t2_pulse_1c", wr_pulse,         0);
    xfer(1'b0, 16'h000A, 16'h0000, 2'b00, rd, sl, w, rdw);
    check("t2_readback", rd,               16'h12EF);

    // Read-only register 7
    xfer(1'b1, 16'h000E, 16'h1111, 2'b11, rd, sl, w, rdw);
    check("t3_wr_err",   sl,               1);
    check("t3_no_pulse", wr_pulse,         0);
    check("t3_cfg7",     cfg_q[127:112],   0);
    hw_status[127:112] = 16'hCAFE;
    xfer(1'b0, 16'h000E, 16'h1111, 2'b00, rd, sl, w, rdw);
    check("t3_rd_data",  rd,               16'hCAFE);
    check("t3_rd_err",   sl,               0);

    // Unaligned and out-of-range accesses
    xfer(1'b0, 16'h0011, 16'h0000, 2'b00, rd, sl, w, rdw);
    check("t4_0011_err", sl, 1);
    check("t4_0011_rd",  rd, 0);
    xfer(1'b0, 16'h0010, 16'h0000, 2'b00, rd, sl, w, rdw);
    check("t4_0010_err", sl, 1);
    check("t4_0010_rd",  rd, 0);
    xfer(1'b0, 16'h0003, 16'h0000, 2'b00, rd, sl, w, rdw);
    check("t4_0003_err", sl, 1);
    check("t4_0003_rd",  rd, 0);
    check("t4_no_prot",  prot_err, 0);

    // Drop penable in T2 of a write to register 0
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0000; bus.pwdata = 16'h5555; bus.pstrb = 2'b11;
    tick();
    bus.penable = 1'b1;
    tick();
    bus.penable = 1'b0;
    tick();
    bus.psel = 1'b0;
    check("t5_prot_set", prot_err,     1);
    check("t5_no_pulse", wr_pulse,     0);
    check("t5_cfg0",     cfg_q[15:0],  0);
    tick();
    check("t5_prot_hold", prot_err,    1);
    xfer(1'b1, 16'h0000, 16'h5A5A, 2'b11, rd, sl, w, rdw);
    check("t5_wr_err",   sl,           0);
    check("t5_pulse",    wr_pulse,     8'h01);
    check("t5_cfg0_new", cfg_q[15:0],  16'h5A5A);
    check("t5_prot_stk", prot_err,     1);

    // Reset in T2 of a write
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0000; bus.pwdata = 16'h7777; bus.pstrb = 2'b11;
    tick();
    bus.penable = 1'b1;
    tick();
    preset = 1'b1;
    tick();
    check("t6_pready",   bus.pready,  0);
    check("t6_pslverr",  bus.pslverr, 0);
    check("t6_prdata",   bus.prdata,  0);
    check("t6_wr_pulse", wr_pulse,    0);
    check("t6_prot_err", prot_err,    0);
    check("t6_cfg_q",    cfg_q,       RV);
    preset = 1'b0;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    tick();
    xfer(1'b1, 16'h0002, 16'h3C3C, 2'b11, rd, sl, w, rdw);
    check("t6_wr_err",   sl, 0);
    check("t6_b2b_pulse", wr_pulse, 8'h02);
    xfer(1'b0, 16'h0002, 16'h3C3C, 2'b00, rd, sl, w, rdw);
    check("t6_b2b_waits", w,  2);
    check("t6_b2b_rd",   rd, 16'h3C3C);
    check("t6_b2b_err",  sl, 0);
    check("t6_no_prot",  prot_err, 0);

    // Access phase from IDLE without setup
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = 16'h0004;
    tick();
    check("t7_pready_a", bus.pready, 0);
    check("t7_prot_err", prot_err,   1);
    tick();
    check("t7_pready_b", bus.pready, 0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB slave with configurable data width, register count, wait states, byte strobes, read-only slots and error responses. Sits between the testbench/host APB master and the DRAM controller. It holds the controller's configuration registers (`cfg_q`) and exposes hardware status words (`hw_status`) for reads. It also detects APB protocol violations and records them in a sticky flag.

## Interface
- `ADDR_W`, 16, APB address width.
- `DATA_W`, 16, data width. Must be a multiple of 8.
- `NUM_REGS`, 8, number of DATA_W-bit registers.
- `WAIT_STATES`, 0, access-phase cycles with `pready`=0 before completion. Range 0..15.
- `RO_MASK`, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only. A read-only register returns `hw_status` slice i.
- `RESET_VAL`, {NUM_REGS*DATA_W{1'b0}}, flat reset image; slice i is the reset value of register i.
- `pclk` in 1: the only clock; all logic on its rising edge.
- `preset` in 1: reset, synchronous, active-high.
- `psel`, `penable`, `pwrite` in 1 each: APB control.
- `paddr` in ADDR_W: byte address.
- `pwdata` in DATA_W: write data.
- `pstrb` in DATA_W/8: write byte-lane enables.
- `prdata` out DATA_W: read data.
- `pready` out 1: transfer completion.
- `pslverr` out 1: error response, valid only while `pready`=1.
- `hw_status` in NUM_REGS*DATA_W: live values read from read-only registers.
- `cfg_q` out NUM_REGS*DATA_W: current contents of RW registers. Read-only slots drive 0.
- `wr_pulse` out NUM_REGS: one-cycle pulse per successful write to register i.
- `prot_err` out 1: sticky APB protocol-violation flag.

## Operation
- Decode: LSB=log2(DATA_W/8).
  - idx = `paddr`[ADDR_W-1:LSB].
  - Unaligned if `paddr`[LSB-1:0]≠0 (only when DATA_W>8).
  - Out-of-range if idx≥NUM_REGS.
- FSM states: IDLE and ACCESS.
  - IDLE, `psel`=1 and `penable`=0 (setup): latch `paddr`, `pwrite`, `pwdata`, `pstrb`; load cnt=WAIT_STATES; go to ACCESS.
  - IDLE, `psel`=1 and `penable`=1 (access without setup): set `prot_err`; stay IDLE; no response.
  - ACCESS, `psel`=1 and `penable`=1: `pready`=(cnt==0). If cnt>0, decrement cnt. If cnt==0, the transfer completes at this edge and the FSM returns to IDLE.
  - ACCESS, `psel`=0 or `penable`=0: set `prot_err`; abort with no write and no `wr_pulse`; go to IDLE.
  - ACCESS, `paddr`, `pwrite` or `pwdata` differs from the latched value: set `prot_err`. The transfer continues with the latched values.
- Errors: `pslverr`=1 with `pready` if the latched address is unaligned, out-of-range, or a write targets a read-only register.
  - Errored write: no state change, no `wr_pulse`.
  - Errored read: `prdata`=0.
- Write commit: at the completion edge, lane b of register idx takes `pwdata` lane b wherever `pstrb`[b]=1.
  - `wr_pulse`[idx]=1 the following cycle, only if `pstrb`≠0.
  - `cfg_q` reflects the new value the following cycle.
- Read data:
  - RW register: `prdata` = stored value.
  - RO register: `prdata` = `hw_status` slice, sampled combinationally during the `pready` cycle.
  - `pstrb` is ignored on reads.
  - `prdata`=0 whenever `pready`=0.
- `prot_err` is cleared only by `preset`.

## Timing
- Reset values:
  - `pready`=0, `pslverr`=0, `prdata`=0, `wr_pulse`=0, `prot_err`=0.
  - Registers = RESET_VAL; `cfg_q` = RESET_VAL with read-only slots at 0.
  - FSM in IDLE.
- `pready`, `pslverr` and `prdata` depend only on registered state plus `hw_status`. There is no combinational path from `psel`, `penable` or `paddr` to `pready`.
- Latency: setup at cycle T0; `pready`=1 at cycle T0+1+WAIT_STATES. A zero-wait transfer takes 2 cycles.
- Back-to-back: a setup in the cycle after completion is accepted. No idle gap is required.
- `preset` mid-transfer aborts the transfer with no write and applies all reset values at the next edge.
- `preset` has priority over every other event.

## Test plan
Configuration for all scenarios: DATA_W=16, NUM_REGS=8, WAIT_STATES=2, RO_MASK=8'h80, RESET_VAL slice 2=16'h00A5.

1. Reset, then read 0x0004:
   - `pready`=0 for access cycles T1 and T2.
   - `pready`=1 at T3 with `prdata`=16'h00A5 and `pslverr`=0.
2. Register 5 holds 16'h1234; write 0x000A, `pwdata`=16'hBEEF, `pstrb`=2'b01:
   - Register 5 becomes 16'h12EF.
   - `wr_pulse`=8'h20 for exactly one cycle after completion.
   - `cfg_q` slice 5 = 16'h12EF.
3. Write 0x000E (read-only register 7):
   - `pslverr`=1, no `wr_pulse`.
   - A following read of 0x000E with `hw_status` slice 7=16'hCAFE returns 16'hCAFE with `pslverr`=0.
4. Read 0x0011 (unaligned) and read 0x0010 (out-of-range):
   - Both return `pslverr`=1 and `prdata`=0 at T3.
5. Drop `penable` in cycle T2 of a write to 0x0000:
   - `prot_err`=1 and stays 1; register 0 is unchanged.
   - A following normal write succeeds.
   - Also drive `psel`=`penable`=1 from IDLE: `prot_err`=1 and no `pready`.
6. Assert `preset` during T2 of a write:
   - Next cycle all outputs take their reset values and register 0 = RESET_VAL.
   - A following zero-gap back-to-back write then read of 0x0002 returns the written data.
